// File: rtl/counter_arb_pkg.sv
// Shared types, defaults and helpers for the counter_arbiter block.
// Round-robin pick and one-hot decode are sized for the largest supported requester count.
`timescale 1ns/1ps
package counter_arb_pkg;

   localparam int          DEF_WIDTH   = 4;
   localparam int          DEF_NUM_REQ = 4;
   localparam int unsigned MAX_REQ     = 8;
   localparam int          PTR_W       = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // First set request at or after ptr, wrapping within the n active lanes.
   function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                  input logic [PTR_W-1:0]   ptr,
                                                  input int unsigned        n);
      logic             found;
      logic [PTR_W-1:0] idx;
      rr_pick = '0;
      found   = 1'b0;
      for (int unsigned k = 0; k < MAX_REQ; k++) begin
         idx = PTR_W'((32'(ptr) + k) % n);
         if (k < n && !found && req[idx]) begin
            rr_pick[idx] = 1'b1;
            found        = 1'b1;
         end
      end
   endfunction

   function automatic logic [PTR_W-1:0] oh_to_idx(input logic [MAX_REQ-1:0] oh);
      oh_to_idx = '0;
      for (int unsigned i = 0; i < MAX_REQ; i++) begin
         if (oh[i]) oh_to_idx = PTR_W'(i);
      end
   endfunction

endpackage

// File: rtl/counter_arbiter_if.sv
// Requester-side bus of counter_arbiter: requests, start values, grant/done and counter status.
`timescale 1ns/1ps
interface counter_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 4
) ();

   logic [NUM_REQ-1:0]       req;
   logic [NUM_REQ*WIDTH-1:0] start_val;
   logic [NUM_REQ-1:0]       grant;
   logic [NUM_REQ-1:0]       done;
   logic                     busy;
   logic [WIDTH-1:0]         cnt_val;
   logic                     abort;

   modport master (output req, start_val,
                   input  grant, done, busy, cnt_val, abort);

   modport slave  (input  req, start_val,
                   output grant, done, busy, cnt_val, abort);

endinterface

// File: rtl/interval_counter.sv
// Loadable up-counter shared by the arbiter; load wins over enable.
`timescale 1ns/1ps
module interval_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             en,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] cnt
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= din;
      end else if (en) begin
         cnt <= cnt + WIDTH'(1);
      end
   end

endmodule

// File: rtl/counter_arbiter.sv
// Round-robin arbiter sharing one interval_counter among NUM_REQ timer clients.
// Optional feature macro: CNT_ARB_ABORT_EN (owner dropping req in LOAD/RUN aborts the run).
`timescale 1ns/1ps
module counter_arbiter
   import counter_arb_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int WIDTH   = DEF_WIDTH
) (
   input logic              clk,
   input logic              reset,
   counter_arbiter_if.slave bus
);

   state_t             state;
   logic [PTR_W-1:0]   rr_ptr;
   logic [PTR_W-1:0]   owner;
   logic [PTR_W-1:0]   next_ptr;
   logic [NUM_REQ-1:0] grant_q;
   logic [NUM_REQ-1:0] done_q;
   logic               busy_q;
   logic [MAX_REQ-1:0] req_ext;
   logic [MAX_REQ-1:0] pick;
   logic [WIDTH-1:0]   din;
   logic [WIDTH-1:0]   cnt;
   logic               load;
   logic               en;
   logic               at_term;

   always_comb begin
      req_ext              = '0;
      req_ext[NUM_REQ-1:0] = bus.req;
   end

   assign pick     = rr_pick(req_ext, rr_ptr, NUM_REQ);
   assign next_ptr = (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + PTR_W'(1);

   always_comb begin
      din = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (owner == PTR_W'(i)) din = bus.start_val[i*WIDTH +: WIDTH];
      end
   end

   // Counter stops at all-ones rather than wrapping; it keeps that value until the next load.
   assign at_term = (cnt == {WIDTH{1'b1}});
   assign load    = (state == ST_LOAD);
   assign en      = (state == ST_RUN) && !at_term;

   interval_counter #(.WIDTH(WIDTH)) u_counter (
      .clk   (clk),
      .reset (reset),
      .load  (load),
      .en    (en),
      .din   (din),
      .cnt   (cnt)
   );

`ifdef CNT_ARB_ABORT_EN
   logic abort_q;
   logic owner_req;

   always_comb begin
      owner_req = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (owner == PTR_W'(i)) owner_req = bus.req[i];
      end
   end
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= ST_IDLE;
         rr_ptr  <= '0;
         owner   <= '0;
         grant_q <= '0;
         done_q  <= '0;
         busy_q  <= 1'b0;
`ifdef CNT_ARB_ABORT_EN
         abort_q <= 1'b0;
`endif
      end else begin
         done_q <= '0;
`ifdef CNT_ARB_ABORT_EN
         abort_q <= 1'b0;
         if ((state == ST_LOAD || state == ST_RUN) && !owner_req) begin
            state   <= ST_IDLE;
            grant_q <= '0;
            busy_q  <= 1'b0;
            abort_q <= 1'b1;
            rr_ptr  <= next_ptr;
         end else
`endif
         case (state)
            ST_IDLE: begin
               if (|bus.req) begin
                  state   <= ST_LOAD;
                  grant_q <= pick[NUM_REQ-1:0];
                  owner   <= oh_to_idx(pick);
                  busy_q  <= 1'b1;
               end
            end
            ST_LOAD: state <= ST_RUN;
            ST_RUN: begin
               if (at_term) begin
                  state  <= ST_DONE;
                  done_q <= grant_q;
               end
            end
            ST_DONE: begin
               state   <= ST_IDLE;
               grant_q <= '0;
               busy_q  <= 1'b0;
               rr_ptr  <= next_ptr;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.grant   = grant_q;
   assign bus.done    = done_q;
   assign bus.busy    = busy_q;
   assign bus.cnt_val = cnt;
`ifdef CNT_ARB_ABORT_EN
   assign bus.abort   = abort_q;
`else
   assign bus.abort   = 1'b0;
`endif

endmodule

// File: tb/tb_counter_arbiter.sv
// Directed bench for counter_arbiter (NUM_REQ=4, WIDTH=4); honours CNT_ARB_ABORT_EN if defined.
`timescale 1ns/1ps
module tb_counter_arbiter;

   logic clk;
   logic reset;
   int   tests;
   int   failed;

   counter_arbiter_if #(.NUM_REQ(4), .WIDTH(4)) bus ();

   counter_arbiter #(.NUM_REQ(4), .WIDTH(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      reset         = 1'b0;
      bus.req       = '0;
      bus.start_val = '0;
      tick();
      tick();
      reset = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      reset         = 1'b0;
      bus.req       = 4'hF;
      bus.start_val = '0;
      tick();
      tick();
      tests++; if (bus.grant !== 4'b0000) begin failed++; $display("FAIL reset_grant: got %b want 0000", bus.grant); end
      tests++; if (bus.busy !== 1'b0) begin failed++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
      tests++; if (bus.cnt_val !== 4'h0) begin failed++; $display("FAIL reset_cnt: got %h want 0", bus.cnt_val); end
      tests++; if (bus.done !== 4'b0000 || bus.abort !== 1'b0) begin failed++; $display("FAIL reset_pulses: done %b abort %b want 0000 0", bus.done, bus.abort); end
      reset = 1'b1;
      tick();
      tests++; if (bus.grant !== 4'b0001) begin failed++; $display("FAIL reset_release_grant: got %b want 0001", bus.grant); end
   endtask

   task automatic test_single();
      logic [3:0] exp_cnt;
      apply_reset();
      bus.start_val = 16'h0C00;
      bus.req       = 4'b0100;
      tick();
      tests++; if (bus.grant !== 4'b0100 || bus.busy !== 1'b1) begin failed++; $display("FAIL single_grant: grant %b busy %b want 0100 1", bus.grant, bus.busy); end
      exp_cnt = 4'hC;
      for (int i = 0; i < 4; i++) begin
         tick();
         tests++; if (bus.cnt_val !== exp_cnt || bus.done !== 4'b0000) begin failed++; $display("FAIL single_run: cnt %h done %b want %h 0000", bus.cnt_val, bus.done, exp_cnt); end
         exp_cnt = exp_cnt + 4'h1;
      end
      tick();
      tests++; if (bus.done !== 4'b0100 || bus.grant !== 4'b0100 || bus.busy !== 1'b1) begin failed++; $display("FAIL single_done: done %b grant %b busy %b want 0100 0100 1", bus.done, bus.grant, bus.busy); end
      bus.req = '0;
      tick();
      tests++; if (bus.done !== 4'b0000 || bus.grant !== 4'b0000 || bus.busy !== 1'b0) begin failed++; $display("FAIL single_idle: done %b grant %b busy %b want 0000 0000 0", bus.done, bus.grant, bus.busy); end
      tests++; if (bus.cnt_val !== 4'hF) begin failed++; $display("FAIL single_hold: cnt %h want f", bus.cnt_val); end
   endtask

   task automatic test_round_robin();
      logic [3:0] exp_g [5];
      int         dones;
      exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      apply_reset();
      bus.start_val = 16'hFFFF;
      bus.req       = 4'hF;
      for (int r = 0; r < 5; r++) begin
         dones = 0;
         tick();
         tests++; if (bus.grant !== exp_g[r]) begin failed++; $display("FAIL rr_grant%0d: got %b want %b", r, bus.grant, exp_g[r]); end
         if (bus.done !== 4'b0000) dones++;
         tick();
         tests++; if (bus.cnt_val !== 4'hF || bus.busy !== 1'b1) begin failed++; $display("FAIL rr_run%0d: cnt %h busy %b want f 1", r, bus.cnt_val, bus.busy); end
         if (bus.done !== 4'b0000) dones++;
         tick();
         tests++; if (bus.done !== exp_g[r] || bus.cnt_val !== 4'hF) begin failed++; $display("FAIL rr_done%0d: done %b cnt %h want %b f", r, bus.done, bus.cnt_val, exp_g[r]); end
         tick();
         tests++; if (bus.grant !== 4'b0000 || bus.busy !== 1'b0) begin failed++; $display("FAIL rr_idle%0d: grant %b busy %b want 0000 0", r, bus.grant, bus.busy); end
         if (bus.done !== 4'b0000) dones++;
         tests++; if (dones !== 0) begin failed++; $display("FAIL rr_extra_done%0d: got %0d stray pulses want 0", r, dones); end
      end
      bus.req = '0;
   endtask

   task automatic test_boundary_zero();
      apply_reset();
      bus.start_val = 16'h0000;
      bus.req       = 4'b0001;
      tick();
      for (int i = 0; i < 16; i++) begin
         tick();
         tests++; if (bus.cnt_val !== 4'(i) || bus.done !== 4'b0000) begin failed++; $display("FAIL zero_run%0d: cnt %h done %b want %h 0000", i, bus.cnt_val, bus.done, 4'(i)); end
      end
      tick();
      tests++; if (bus.done !== 4'b0001 || bus.cnt_val !== 4'hF) begin failed++; $display("FAIL zero_done: done %b cnt %h want 0001 f", bus.done, bus.cnt_val); end
      bus.req = '0;
      tick();
      tests++; if (bus.cnt_val !== 4'hF || bus.busy !== 1'b0) begin failed++; $display("FAIL zero_nowrap: cnt %h busy %b want f 0", bus.cnt_val, bus.busy); end
   endtask

   task automatic test_reset_mid_run();
      apply_reset();
      bus.start_val = 16'h6000;
      bus.req       = 4'b1000;
      tick();
      for (int i = 0; i < 4; i++) tick();
      tests++; if (bus.cnt_val !== 4'h9 || bus.grant !== 4'b1000) begin failed++; $display("FAIL midrst_pre: cnt %h grant %b want 9 1000", bus.cnt_val, bus.grant); end
      reset = 1'b0;
      #1;
      tests++; if (bus.grant !== 4'b0000 || bus.cnt_val !== 4'h0 || bus.busy !== 1'b0) begin failed++; $display("FAIL midrst_async: grant %b cnt %h busy %b want 0000 0 0", bus.grant, bus.cnt_val, bus.busy); end
      tick();
      tests++; if (bus.done !== 4'b0000 || bus.abort !== 1'b0) begin failed++; $display("FAIL midrst_pulse: done %b abort %b want 0000 0", bus.done, bus.abort); end
      bus.req = '0;
      reset   = 1'b1;
      tick();
   endtask

   task automatic test_abort();
      apply_reset();
      bus.start_val = 16'h0F00;
      bus.req       = 4'b0010;
      tick();
      tests++; if (bus.grant !== 4'b0010) begin failed++; $display("FAIL abort_grant: got %b want 0010", bus.grant); end
      for (int i = 0; i < 6; i++) tick();
      tests++; if (bus.cnt_val !== 4'h5) begin failed++; $display("FAIL abort_pre: cnt %h want 5", bus.cnt_val); end
      bus.req = 4'b0100;
`ifdef CNT_ARB_ABORT_EN
      tick();
      tests++; if (bus.abort !== 1'b1 || bus.grant !== 4'b0000 || bus.done !== 4'b0000) begin failed++; $display("FAIL abort_pulse: abort %b grant %b done %b want 1 0000 0000", bus.abort, bus.grant, bus.done); end
      tick();
      tests++; if (bus.abort !== 1'b0 || bus.grant !== 4'b0100) begin failed++; $display("FAIL abort_next: abort %b grant %b want 0 0100", bus.abort, bus.grant); end
      tick();
      tick();
      tests++; if (bus.done !== 4'b0100) begin failed++; $display("FAIL abort_next_done: done %b want 0100", bus.done); end
`else
      for (int i = 6; i < 16; i++) begin
         tick();
         tests++; if (bus.cnt_val !== 4'(i) || bus.grant !== 4'b0010 || bus.abort !== 1'b0) begin failed++; $display("FAIL noabort_run%0d: cnt %h grant %b abort %b want %h 0010 0", i, bus.cnt_val, bus.grant, bus.abort, 4'(i)); end
      end
      tick();
      tests++; if (bus.done !== 4'b0010 || bus.abort !== 1'b0) begin failed++; $display("FAIL noabort_done: done %b abort %b want 0010 0", bus.done, bus.abort); end
      tick();
      tick();
      tests++; if (bus.grant !== 4'b0100) begin failed++; $display("FAIL noabort_next: grant %b want 0100", bus.grant); end
`endif
      bus.req = '0;
   endtask

   initial begin
      tests         = 0;
      failed        = 0;
      reset         = 1'b0;
      bus.req       = '0;
      bus.start_val = '0;
      test_reset();
      test_single();
      test_round_robin();
      test_boundary_zero();
      test_reset_mid_run();
      test_abort();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
